// File: rtl/uart_dump_pkg.sv
// Shared types and constants for the SRAM-to-UART dump block.
// Optional feature macro: UART_DUMP_PPM_HEADER_EN (adds the S_HEADER state).
package uart_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef UART_DUMP_PPM_HEADER_EN
        S_HEADER,
`endif
        S_READ_REQ,
        S_READ_WAIT,
        S_SEND_HI,
        S_SEND_LO,
        S_DONE
    } dump_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int PPM_HEADER_LEN = 15;

    // "P6\n320 240\n255\n"
    localparam logic [7:0] PPM_HEADER [0:PPM_HEADER_LEN-1] = '{
        8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20, 8'h32,
        8'h34, 8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A
    };

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter. Tx_busy rises the cycle after Tx_start and stays
// high through the last stop-bit cycle; Tx_done marks that last cycle so the
// caller can react without losing a cycle.
module uart_tx_byte
    import uart_dump_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434
) (
    input  logic       Clock_50,
    input  logic       Resetn,
    input  logic       Tx_start,
    input  logic [7:0] Tx_data,
    output logic       Tx_busy,
    output logic       Tx_done,
    output logic       Tx_o
);

    localparam int BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

    tx_state_t         state_r, state_s;
    logic [BAUD_W-1:0] baud_r, baud_s;
    logic [2:0]        bit_r, bit_s;
    logic [7:0]        shift_r, shift_s;
    logic              tx_o_r, tx_o_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    // Next-state logic: walks start, data and stop bits, each BAUD_LAST+1 cycles long
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        tx_o_s  = tx_o_r;
        case (state_r)
            TX_IDLE: begin
                tx_o_s = 1'b1;
                if (Tx_start) begin
                    state_s = TX_START;
                    baud_s  = '0;
                    shift_s = Tx_data;
                    tx_o_s  = 1'b0;
                end else begin
                    state_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = '0;
                    bit_s   = 3'd0;
                    state_s = TX_DATA;
                    tx_o_s  = shift_r[0];
                end else begin
                    baud_s = baud_r + 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s = '0;
                    if (bit_r == 3'd7) begin
                        state_s = TX_STOP;
                        tx_o_s  = 1'b1;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        shift_s = {1'b0, shift_r[7:1]};
                        tx_o_s  = shift_r[1];
                    end
                end else begin
                    baud_s = baud_r + 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = '0;
                    state_s = TX_IDLE;
                end else begin
                    baud_s = baud_r + 1'b1;
                end
            end
            default: begin
                state_s = TX_IDLE;
                baud_s  = '0;
                tx_o_s  = 1'b1;
            end
        endcase
        busy_s = (state_s != TX_IDLE);
        done_s = (state_s == TX_STOP) && (baud_s == BAUD_LAST);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clock_50) begin
        if (!Resetn) begin
            state_r <= TX_IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_o_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_o_r  <= tx_o_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign Tx_busy = busy_r;
    assign Tx_done = done_r;
    assign Tx_o    = tx_o_r;

endmodule

// File: rtl/sram_uart_dump.sv
// Reads Word_count 16-bit SRAM words from Base_address and sends them over
// UART 8N1, high byte first. Owns the SRAM port while Busy=1.
// Optional feature macro: UART_DUMP_PPM_HEADER_EN (prefixes a 15-byte PPM header).
module sram_uart_dump
    import uart_dump_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int READ_LATENCY   = 2
) (
    input  logic        Clock_50,
    input  logic        Resetn,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [17:0] Word_count,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done
);

    dump_state_t state_r, state_s;
    logic [17:0] addr_r, addr_s;
    logic [17:0] base_r, base_s;
    logic [17:0] count_r, count_s;
    logic [17:0] index_r, index_s;
    logic [15:0] word_r, word_s;
    logic [2:0]  lat_r, lat_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        we_n_r;
    logic        tx_start_s;
    logic [7:0]  tx_data_s;
    logic        tx_busy_s;
    logic        tx_done_s;
`ifdef UART_DUMP_PPM_HEADER_EN
    logic [3:0]  hdr_r, hdr_s;
`endif

    uart_tx_byte #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_tx (
        .Clock_50(Clock_50),
        .Resetn  (Resetn),
        .Tx_start(tx_start_s),
        .Tx_data (tx_data_s),
        .Tx_busy (tx_busy_s),
        .Tx_done (tx_done_s),
        .Tx_o    (UART_TX_O)
    );

    // Dump sequencer: header, SRAM read with fixed latency, then hi/lo byte hand-off
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        base_s     = base_r;
        count_s    = count_r;
        index_s    = index_r;
        word_s     = word_r;
        lat_s      = lat_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        tx_start_s = 1'b0;
        tx_data_s  = 8'h00;
`ifdef UART_DUMP_PPM_HEADER_EN
        hdr_s      = hdr_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (Start) begin
                    base_s  = Base_address;
                    count_s = Word_count;
                    index_s = 18'd0;
`ifdef UART_DUMP_PPM_HEADER_EN
                    hdr_s   = 4'd0;
                    busy_s  = 1'b1;
                    state_s = S_HEADER;
`else
                    if (Word_count == 18'd0) begin
                        done_s = 1'b1;
                    end else begin
                        busy_s  = 1'b1;
                        state_s = S_READ_REQ;
                    end
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
`ifdef UART_DUMP_PPM_HEADER_EN
            S_HEADER: begin
                if (!tx_busy_s) begin
                    tx_start_s = 1'b1;
                    tx_data_s  = PPM_HEADER[hdr_r];
                    if (hdr_r == 4'(PPM_HEADER_LEN - 1)) begin
                        if (count_r == 18'd0) begin
                            state_s = S_DONE;
                        end else begin
                            state_s = S_READ_REQ;
                        end
                    end else begin
                        hdr_s = hdr_r + 4'd1;
                    end
                end else begin
                    state_s = S_HEADER;
                end
            end
`endif
            S_READ_REQ: begin
                addr_s  = base_r + index_r;
                lat_s   = 3'd0;
                state_s = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                // Address is registered, so it is on the pins from the first wait cycle
                if (lat_r == 3'(READ_LATENCY)) begin
                    word_s  = SRAM_read_data;
                    state_s = S_SEND_HI;
                end else begin
                    lat_s = lat_r + 3'd1;
                end
            end
            S_SEND_HI: begin
                if (!tx_busy_s) begin
                    tx_start_s = 1'b1;
                    tx_data_s  = word_r[15:8];
                    state_s    = S_SEND_LO;
                end else begin
                    state_s = S_SEND_HI;
                end
            end
            S_SEND_LO: begin
                if (!tx_busy_s) begin
                    tx_start_s = 1'b1;
                    tx_data_s  = word_r[7:0];
                    // The next read overlaps the low-byte frame
                    if (index_r + 18'd1 == count_r) begin
                        state_s = S_DONE;
                    end else begin
                        index_s = index_r + 18'd1;
                        state_s = S_READ_REQ;
                    end
                end else begin
                    state_s = S_SEND_LO;
                end
            end
            S_DONE: begin
                if (tx_done_s) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Sequencer registers with synchronous active-low reset
    always_ff @(posedge Clock_50) begin
        if (!Resetn) begin
            state_r <= S_IDLE;
            addr_r  <= 18'd0;
            base_r  <= 18'd0;
            count_r <= 18'd0;
            index_r <= 18'd0;
            word_r  <= 16'h0000;
            lat_r   <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            we_n_r  <= 1'b1;
`ifdef UART_DUMP_PPM_HEADER_EN
            hdr_r   <= 4'd0;
`endif
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            base_r  <= base_s;
            count_r <= count_s;
            index_r <= index_s;
            word_r  <= word_s;
            lat_r   <= lat_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            we_n_r  <= 1'b1;
`ifdef UART_DUMP_PPM_HEADER_EN
            hdr_r   <= hdr_s;
`endif
        end
    end

    assign SRAM_address = addr_r;
    assign SRAM_we_n    = we_n_r;
    assign Busy         = busy_r;
    assign Done         = done_r;

endmodule

// File: tb/tb_sram_uart_dump.sv
// Directed self-checking bench for sram_uart_dump (CLOCKS_PER_BIT=4, READ_LATENCY=2).
module tb_sram_uart_dump;

    localparam int CPB = 4;
    localparam int RL  = 2;
`ifdef UART_DUMP_PPM_HEADER_EN
    localparam int HN  = 15;
`else
    localparam int HN  = 0;
`endif

    logic        clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        Start = 1'b0;
    logic [17:0] Base_address = 18'd0;
    logic [17:0] Word_count = 18'd0;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic        UART_TX_O;
    logic        Busy;
    logic        Done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;

    // Observation state, written only by the monitors below
    logic [7:0]  rx_q[$];
    int          fs_q[$];
    logic [17:0] addr_q[$];
    logic [17:0] prev_addr = 18'd0;
    int          ferr_total = 0;
    int          done_total = 0;
    int          done_cyc = 0;
    logic        busy_at_done = 1'b0;
    int          busy_total = 0;
    int          low_total = 0;

    logic [15:0] mem [logic [17:0]];
    logic [15:0] rd1 = 16'h0000;
    logic [15:0] rd2 = 16'h0000;

    sram_uart_dump #(.CLOCKS_PER_BIT(CPB), .READ_LATENCY(RL)) dut (
        .Clock_50      (clk),
        .Resetn        (Resetn),
        .Start         (Start),
        .Base_address  (Base_address),
        .Word_count    (Word_count),
        .SRAM_address  (SRAM_address),
        .SRAM_we_n     (SRAM_we_n),
        .SRAM_read_data(SRAM_read_data),
        .UART_TX_O     (UART_TX_O),
        .Busy          (Busy),
        .Done          (Done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] sram_val(input logic [17:0] a);
        if (mem.exists(a)) return mem[a];
        else return 16'hDEAD;
    endfunction

    // SRAM model with two cycles of read latency
    always @(posedge clk) begin
        rd1 <= sram_val(SRAM_address);
        rd2 <= rd1;
    end
    assign SRAM_read_data = rd2;

    // Signal monitors
    always @(negedge clk) begin
        if (Done === 1'b1) begin
            done_total++;
            done_cyc = cyc;
            busy_at_done = Busy;
        end
        if (Busy === 1'b1) busy_total++;
        if (UART_TX_O === 1'b0) low_total++;
        if (SRAM_address !== prev_addr) begin
            addr_q.push_back(SRAM_address);
            prev_addr = SRAM_address;
        end
    end

    // UART receiver sampling at bit centres
    initial begin
        logic [7:0] rxb;
        int c0;
        forever begin
            @(negedge clk);
            if (Resetn === 1'b1 && UART_TX_O === 1'b0) begin
                c0 = cyc;
                fs_q.push_back(c0);
                repeat (CPB / 2) @(negedge clk);
                if (UART_TX_O !== 1'b0) ferr_total++;
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rxb[b] = UART_TX_O;
                end
                repeat (CPB) @(negedge clk);
                if (UART_TX_O !== 1'b1) ferr_total++;
                rx_q.push_back(rxb);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [17:0] base, input logic [17:0] cnt);
        @(negedge clk);
        Start = 1'b1;
        Base_address = base;
        Word_count = cnt;
        start_cyc = cyc;
        @(negedge clk);
        Start = 1'b0;
        Base_address = 18'h2AAAA;
        Word_count = 18'h15555;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_total == d0; i++) @(negedge clk);
        n_checks++;
        if (done_total == d0) begin
            n_fail++;
            $display("FAIL done_timeout: got no Done within %0d cycles, required one", budget);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && fs_q.size() < n; i++) @(negedge clk);
        n_checks++;
        if (fs_q.size() < n) begin
            n_fail++;
            $display("FAIL frame_timeout: got %0d frame starts, required %0d", fs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (SRAM_address !== 18'd0) begin n_fail++; $display("FAIL rst_addr: got %h required 0", SRAM_address); end
        n_checks++; if (SRAM_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n: got %b required 1", SRAM_we_n); end
        n_checks++; if (UART_TX_O !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b required 1", UART_TX_O); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", Busy); end
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", Done); end
        Resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int rb, fb, d0, e0;
        logic [7:0] exp_b [4];
        exp_b = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
        mem[18'h100] = 16'hA55A;
        mem[18'h101] = 16'h00FF;
        rb = rx_q.size(); fb = fs_q.size(); d0 = done_total; e0 = ferr_total;
        do_start(18'h100, 18'd2);
        wait_done(d0, 2000);
        repeat (20) @(negedge clk);
        n_checks++; if (rx_q.size() - rb !== HN + 4) begin n_fail++; $display("FAIL basic_count: got %0d bytes required %0d", rx_q.size() - rb, HN + 4); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx_q.size() > rb + HN + i && rx_q[rb + HN + i] !== exp_b[i]) begin
                n_fail++; $display("FAIL basic_byte%0d: got %h required %h", i, rx_q[rb + HN + i], exp_b[i]);
            end else if (rx_q.size() <= rb + HN + i) begin
                n_fail++; $display("FAIL basic_byte%0d: missing, required %h", i, exp_b[i]);
            end
        end
        if (fs_q.size() >= fb + HN + 4) begin
            n_checks++; if (fs_q[fb+HN+1] - fs_q[fb+HN] < 10*CPB || fs_q[fb+HN+1] - fs_q[fb+HN] > 10*CPB + 1) begin n_fail++; $display("FAIL basic_gap_hilo0: got %0d cycles required 40..41", fs_q[fb+HN+1] - fs_q[fb+HN]); end
            n_checks++; if (fs_q[fb+HN+2] - fs_q[fb+HN+1] < 10*CPB || fs_q[fb+HN+2] - fs_q[fb+HN+1] > 10*CPB + RL + 2) begin n_fail++; $display("FAIL basic_gap_word: got %0d cycles required 40..44", fs_q[fb+HN+2] - fs_q[fb+HN+1]); end
            n_checks++; if (fs_q[fb+HN+3] - fs_q[fb+HN+2] < 10*CPB || fs_q[fb+HN+3] - fs_q[fb+HN+2] > 10*CPB + 1) begin n_fail++; $display("FAIL basic_gap_hilo1: got %0d cycles required 40..41", fs_q[fb+HN+3] - fs_q[fb+HN+2]); end
            n_checks++; if (done_cyc !== fs_q[fb+HN+3] + 10*CPB) begin n_fail++; $display("FAIL basic_done_time: got cycle %0d required %0d", done_cyc, fs_q[fb+HN+3] + 10*CPB); end
        end else begin
            n_checks++; n_fail++; $display("FAIL basic_frames: got %0d frame starts required %0d", fs_q.size() - fb, HN + 4);
        end
        n_checks++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d required 1", done_total - d0); end
        n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b required 0", busy_at_done); end
        n_checks++; if (ferr_total !== e0) begin n_fail++; $display("FAIL basic_framing: got %0d errors required 0", ferr_total - e0); end
    endtask

    task automatic test_zero_count();
        int rb, d0, b0, l0;
        rb = rx_q.size(); d0 = done_total; b0 = busy_total; l0 = low_total;
        do_start(18'h100, 18'd0);
`ifdef UART_DUMP_PPM_HEADER_EN
        wait_done(d0, 2000);
        repeat (20) @(negedge clk);
        n_checks++; if (rx_q.size() - rb !== HN) begin n_fail++; $display("FAIL zero_hdr_count: got %0d bytes required %0d", rx_q.size() - rb, HN); end
`else
        repeat (20) @(negedge clk);
        n_checks++; if (done_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL zero_done_time: got cycle %0d required %0d", done_cyc, start_cyc + 1); end
        n_checks++; if (busy_total !== b0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles required 0", busy_total - b0); end
        n_checks++; if (low_total !== l0) begin n_fail++; $display("FAIL zero_tx: got %0d low cycles required 0", low_total - l0); end
        n_checks++; if (rx_q.size() !== rb) begin n_fail++; $display("FAIL zero_bytes: got %0d bytes required 0", rx_q.size() - rb); end
`endif
        n_checks++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d required 1", done_total - d0); end
    endtask

    task automatic test_start_while_busy();
        int rb, fb, d0;
        logic [7:0] exp_b [6];
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        mem[18'h000] = 16'h0102;
        mem[18'h001] = 16'h0304;
        mem[18'h002] = 16'h0506;
        mem[18'h200] = 16'hBAD0;
        mem[18'h201] = 16'hBAD1;
        rb = rx_q.size(); fb = fs_q.size(); d0 = done_total;
        do_start(18'h000, 18'd3);
        wait_frames(fb + 2, 500);
        repeat (5) @(negedge clk);
        do_start(18'h200, 18'd5);
        wait_done(d0, 3000);
        repeat (100) @(negedge clk);
        n_checks++; if (rx_q.size() - rb !== HN + 6) begin n_fail++; $display("FAIL busy_count: got %0d bytes required %0d", rx_q.size() - rb, HN + 6); end
        for (int i = 0; i < 6; i++) begin
            if (rx_q.size() > rb + HN + i) begin
                n_checks++; if (rx_q[rb + HN + i] !== exp_b[i]) begin n_fail++; $display("FAIL busy_byte%0d: got %h required %h", i, rx_q[rb + HN + i], exp_b[i]); end
            end
        end
        n_checks++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d required 1", done_total - d0); end
    endtask

    task automatic test_addr_wrap();
        int rb, d0, a0;
        logic [7:0] exp_b [4];
        exp_b = '{8'hBE, 8'hEF, 8'h01, 8'h02};
        mem[18'h3FFFF] = 16'hBEEF;
        rb = rx_q.size(); d0 = done_total; a0 = addr_q.size();
        do_start(18'h3FFFF, 18'd2);
        wait_done(d0, 2000);
        repeat (20) @(negedge clk);
        n_checks++; if (addr_q.size() - a0 !== 2) begin n_fail++; $display("FAIL wrap_addr_count: got %0d addresses required 2", addr_q.size() - a0); end
        if (addr_q.size() >= a0 + 2) begin
            n_checks++; if (addr_q[a0] !== 18'h3FFFF) begin n_fail++; $display("FAIL wrap_addr0: got %h required 3ffff", addr_q[a0]); end
            n_checks++; if (addr_q[a0+1] !== 18'h00000) begin n_fail++; $display("FAIL wrap_addr1: got %h required 00000", addr_q[a0+1]); end
        end
        n_checks++; if (rx_q.size() - rb !== HN + 4) begin n_fail++; $display("FAIL wrap_count: got %0d bytes required %0d", rx_q.size() - rb, HN + 4); end
        for (int i = 0; i < 4; i++) begin
            if (rx_q.size() > rb + HN + i) begin
                n_checks++; if (rx_q[rb + HN + i] !== exp_b[i]) begin n_fail++; $display("FAIL wrap_byte%0d: got %h required %h", i, rx_q[rb + HN + i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int rb, fb, d0, e0;
        mem[18'h010] = 16'h0000;
        mem[18'h011] = 16'h1111;
        mem[18'h012] = 16'h2222;
        mem[18'h013] = 16'h3333;
        mem[18'h020] = 16'hC33C;
        fb = fs_q.size(); d0 = done_total;
        do_start(18'h010, 18'd4);
        wait_frames(fb + 1, 500);
        repeat (9) @(negedge clk);
        Resetn = 1'b0;
        @(negedge clk);
        n_checks++; if (UART_TX_O !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b required 1", UART_TX_O); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", Busy); end
        repeat (2) @(negedge clk);
        Resetn = 1'b1;
        repeat (60) @(negedge clk);
        n_checks++; if (done_total !== d0) begin n_fail++; $display("FAIL midrst_done: got %0d Done pulses required 0", done_total - d0); end
        rb = rx_q.size(); d0 = done_total; e0 = ferr_total;
        do_start(18'h020, 18'd1);
        wait_done(d0, 2000);
        repeat (20) @(negedge clk);
        n_checks++; if (rx_q.size() - rb !== HN + 2) begin n_fail++; $display("FAIL midrst_count: got %0d bytes required %0d", rx_q.size() - rb, HN + 2); end
        if (rx_q.size() >= rb + HN + 2) begin
            n_checks++; if (rx_q[rb + HN] !== 8'hC3) begin n_fail++; $display("FAIL midrst_hi: got %h required c3", rx_q[rb + HN]); end
            n_checks++; if (rx_q[rb + HN + 1] !== 8'h3C) begin n_fail++; $display("FAIL midrst_lo: got %h required 3c", rx_q[rb + HN + 1]); end
        end
        n_checks++; if (ferr_total !== e0) begin n_fail++; $display("FAIL midrst_framing: got %0d errors required 0", ferr_total - e0); end
    endtask

`ifdef UART_DUMP_PPM_HEADER_EN
    task automatic test_header();
        int rb, d0;
        logic [7:0] exp_b [17];
        exp_b = '{8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20, 8'h32, 8'h34,
                  8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A, 8'h12, 8'h34};
        mem[18'h040] = 16'h1234;
        rb = rx_q.size(); d0 = done_total;
        do_start(18'h040, 18'd1);
        wait_done(d0, 3000);
        repeat (20) @(negedge clk);
        n_checks++; if (rx_q.size() - rb !== 17) begin n_fail++; $display("FAIL hdr_count: got %0d bytes required 17", rx_q.size() - rb); end
        for (int i = 0; i < 17; i++) begin
            if (rx_q.size() > rb + i) begin
                n_checks++; if (rx_q[rb + i] !== exp_b[i]) begin n_fail++; $display("FAIL hdr_byte%0d: got %h required %h", i, rx_q[rb + i], exp_b[i]); end
            end
        end
        n_checks++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL hdr_done_count: got %0d required 1", done_total - d0); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_start_while_busy();
        test_addr_wrap();
        test_reset_mid_frame();
`ifdef UART_DUMP_PPM_HEADER_EN
        test_header();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
